store_drain_unit: RTL and testbench
===================================

Name: store_drain_unit

Overview:
- Consumer end of the store buffer head interface: sits between the store buffer's entry-0 outputs and the memory system.
- Pops one committed store per handshake and retires it:
  - cached stores go to the data-cache write port;
  - uncached stores go out as single-beat AXI3/AXI4 write transactions.
- Drives `cache_is_busy` back to the store buffer; the store buffer shifts its head out in any cycle where busy is low.

Parameters:
- AXI_ID_W, 4, width of awid/bid
- AXI_WR_ID, 4'd1, constant awid used for all uncached writes
- CNT_W, 32, width of the retired-store counters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- sb_store_data  in  32  head store data
- sb_store_addr  in  32  head store byte address
- sb_store_rwen  in  4  head byte enables
- sb_store_en  in  1  head valid, cached store
- sb_store_uncache  in  1  head valid, uncached store (mutually exclusive with sb_store_en)
- cache_is_busy  out  1  high = head must not be popped this cycle
- dc_wr_req  out  1  cache write request
- dc_wr_addr  out  32  cache write address
- dc_wr_data  out  32  cache write data
- dc_wr_wstrb  out  4  cache byte strobes
- dc_wr_ack  in  1  cache write done (may take many cycles on miss)
- awid  out  AXI_ID_W  AXI write ID
- awaddr  out  32  AXI write address
- awlen  out  8  AXI burst length
- awsize  out  3  AXI transfer size
- awburst  out  2  AXI burst type
- awvalid  out  1  AXI address valid
- awready  in  1  AXI address ready
- wdata  out  32  AXI write data
- wstrb  out  4  AXI write strobes
- wlast  out  1  AXI last beat
- wvalid  out  1  AXI data valid
- wready  in  1  AXI data ready
- bid  in  AXI_ID_W  AXI response ID
- bresp  in  2  AXI write response
- bvalid  in  1  AXI response valid
- bready  out  1  AXI response ready
- bus_err  out  1  sticky: an uncached write returned bresp != OKAY
- cached_cnt  out  CNT_W  cached stores retired
- uncached_cnt  out  CNT_W  uncached stores retired

Behaviour:
- Reset: state=IDLE. All request/valid outputs 0, bready 0, bus_err 0, counters 0, holding registers 0, cache_is_busy 0.
- cache_is_busy = (state != IDLE). It is decoded from registered state only and has no combinational path from any input.
- Pop rule: in IDLE, when sb_store_en or sb_store_uncache is high, latch addr, data, rwen and the uncache flag at the clock edge; the store buffer drops its head on that same edge.
- Transitions out of IDLE on a pop:
  - rwen==0 → retire as no-op, stay IDLE, no counter change;
  - cached → C_WR;
  - uncached → U_REQ.
- C_WR:
  - dc_wr_req=1 with latched fields.
  - On dc_wr_ack → cached_cnt+1, go to IDLE; the next pop is possible the cycle after.
  - Minimum occupancy is 1 cycle, so best-case throughput is 1 store per 2 cycles.
- U_REQ:
  - awvalid and wvalid both asserted from state entry.
  - Each channel deasserts independently on its own valid&ready; per-channel done flags are kept.
  - When both are done (same cycle allowed) → U_RESP.
  - Payload is held stable while valid is high.
- U_RESP: bready=1. On bvalid:
  - uncached_cnt+1, go to IDLE;
  - if bresp!=2'b00, set bus_err (cleared only by rst);
  - bid is not checked.
- AXI field encoding:
  - awlen=0, awburst=2'b01, wlast=1, awid=AXI_WR_ID.
  - wdata = data unmodified; wstrb = rwen.
  - awsize: rwen 1111 → 2; 0011/1100 → 1; one-hot → 0; any other pattern → 2.
  - awaddr = {addr[31:2], off}, where off = index of lowest set rwen bit for size 0; 0 or 2 for size 1; 00 for size 2.
- Invariants:
  - Only one store is outstanding at a time, so program order of stores is preserved across the cached and uncached paths.
  - The store buffer's flush does not affect this block; a popped store always completes.
- Simultaneous sb_store_en & sb_store_uncache is illegal; the uncached path takes priority.
- rst mid-transaction returns to IDLE immediately and abandons the in-flight access. The system guarantees the bus is also reset.
- Counters wrap modulo 2^CNT_W.

Test Plan:
- Cached store addr 0x1000, data 0xDEADBEEF, rwen 1111; ack 3 cycles after req → busy high for 4 cycles; dc_wr_* matches; cached_cnt=1.
- Uncached store addr 0x1FD0_0003, rwen 1000; awready 2 cycles late, wready immediate → awaddr=0x1FD0_0003, awsize=0, wstrb=1000; single AW and W handshake each; bready only after both.
- Back-to-back stores: cached, uncached, cached with ack/bvalid immediate → AXI B for the uncached store precedes the third dc_wr_req; exactly 3 pops; counters 2/1.
- bresp=2'b10 on an uncached write → bus_err=1 and stays set through later OKAY writes; uncached_cnt still increments.
- Pop with rwen=0000 → no dc_wr_req or awvalid; busy stays 0; counters unchanged.
- rst asserted in U_REQ with awvalid high → next cycle awvalid=0, wvalid=0, busy=0, counters 0.

Source files
------------

// File: rtl/store_drain_unit.sv
// Drains committed stores from the store buffer head, one at a time, to either the
// data-cache write port (cached) or a single-beat AXI write (uncached).
module store_drain_unit #(
  parameter int unsigned          AXI_ID_W  = 4,
  parameter logic [AXI_ID_W-1:0]  AXI_WR_ID = 4'd1,
  parameter int unsigned          CNT_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  // Store buffer head
  input  logic [31:0]         sb_store_data,
  input  logic [31:0]         sb_store_addr,
  input  logic [3:0]          sb_store_rwen,
  input  logic                sb_store_en,
  input  logic                sb_store_uncache,
  output logic                cache_is_busy,
  // Data-cache write port
  output logic                dc_wr_req,
  output logic [31:0]         dc_wr_addr,
  output logic [31:0]         dc_wr_data,
  output logic [3:0]          dc_wr_wstrb,
  input  logic                dc_wr_ack,
  // AXI write address
  output logic [AXI_ID_W-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  // AXI write data
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  // AXI write response
  input  logic [AXI_ID_W-1:0] bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  // Status
  output logic                bus_err,
  output logic [CNT_W-1:0]    cached_cnt,
  output logic [CNT_W-1:0]    uncached_cnt
);

  typedef enum logic [1:0] {StIdle, StCWr, StUReq, StUResp} state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [3:0]       rwen_q, rwen_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] cached_cnt_q, cached_cnt_d;
  logic [CNT_W-1:0] uncached_cnt_q, uncached_cnt_d;

  logic [1:0]       off;
  logic             unused_bid;

  // The response ID is intentionally ignored: only one write is ever outstanding.
  assign unused_bid = ^bid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      data_q         <= '0;
      rwen_q         <= '0;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      bus_err_q      <= 1'b0;
      cached_cnt_q   <= '0;
      uncached_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      rwen_q         <= rwen_d;
      aw_done_q      <= aw_done_d;
      w_done_q       <= w_done_d;
      bus_err_q      <= bus_err_d;
      cached_cnt_q   <= cached_cnt_d;
      uncached_cnt_q <= uncached_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    data_d         = data_q;
    rwen_d         = rwen_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    bus_err_d      = bus_err_q;
    cached_cnt_d   = cached_cnt_q;
    uncached_cnt_d = uncached_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (sb_store_en || sb_store_uncache) begin
          addr_d = sb_store_addr;
          data_d = sb_store_data;
          rwen_d = sb_store_rwen;
          // An empty byte mask retires as a no-op without touching memory.
          if (sb_store_rwen != 4'b0000) begin
            if (sb_store_uncache) begin
              state_d   = StUReq;
              aw_done_d = 1'b0;
              w_done_d  = 1'b0;
            end else begin
              state_d = StCWr;
            end
          end
        end
      end
      StCWr: begin
        if (dc_wr_ack) begin
          cached_cnt_d = cached_cnt_q + CNT_W'(1);
          state_d      = StIdle;
        end
      end
      StUReq: begin
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) begin
          state_d = StUResp;
        end
      end
      StUResp: begin
        if (bvalid) begin
          uncached_cnt_d = uncached_cnt_q + CNT_W'(1);
          if (bresp != 2'b00) begin
            bus_err_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Transfer size and low address bits follow from the byte-enable pattern.
  always_comb begin
    awsize = 3'd2;
    off    = 2'd0;
    case (rwen_q)
      4'b1111: begin awsize = 3'd2; off = 2'd0; end
      4'b0011: begin awsize = 3'd1; off = 2'd0; end
      4'b1100: begin awsize = 3'd1; off = 2'd2; end
      4'b0001: begin awsize = 3'd0; off = 2'd0; end
      4'b0010: begin awsize = 3'd0; off = 2'd1; end
      4'b0100: begin awsize = 3'd0; off = 2'd2; end
      4'b1000: begin awsize = 3'd0; off = 2'd3; end
      default: begin awsize = 3'd2; off = 2'd0; end
    endcase
  end

  assign cache_is_busy = (state_q != StIdle);

  assign dc_wr_req   = (state_q == StCWr);
  assign dc_wr_addr  = addr_q;
  assign dc_wr_data  = data_q;
  assign dc_wr_wstrb = rwen_q;

  assign awid    = AXI_WR_ID;
  assign awaddr  = {addr_q[31:2], off};
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign awvalid = (state_q == StUReq) && !aw_done_q;

  assign wdata  = data_q;
  assign wstrb  = rwen_q;
  assign wlast  = 1'b1;
  assign wvalid = (state_q == StUReq) && !w_done_q;

  assign bready = (state_q == StUResp);

  assign bus_err      = bus_err_q;
  assign cached_cnt   = cached_cnt_q;
  assign uncached_cnt = uncached_cnt_q;

endmodule

// File: tb/tb_store_drain_unit.sv
// Scoreboard bench for store_drain_unit: a store-buffer model feeds the head, random
// cache/AXI responders answer, and a negedge monitor checks every retirement in order.
module tb_store_drain_unit;

  localparam int unsigned AXI_ID_W = 4;
  localparam int unsigned CNT_W    = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [31:0]         sb_store_data = '0;
  logic [31:0]         sb_store_addr = '0;
  logic [3:0]          sb_store_rwen = '0;
  logic                sb_store_en = 1'b0;
  logic                sb_store_uncache = 1'b0;
  logic                cache_is_busy;
  logic                dc_wr_req;
  logic [31:0]         dc_wr_addr;
  logic [31:0]         dc_wr_data;
  logic [3:0]          dc_wr_wstrb;
  logic                dc_wr_ack = 1'b0;
  logic [AXI_ID_W-1:0] awid;
  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready = 1'b0;
  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready = 1'b0;
  logic [AXI_ID_W-1:0] bid = '0;
  logic [1:0]          bresp = 2'b00;
  logic                bvalid = 1'b0;
  logic                bready;
  logic                bus_err;
  logic [CNT_W-1:0]    cached_cnt;
  logic [CNT_W-1:0]    uncached_cnt;

  store_drain_unit #(
    .AXI_ID_W (AXI_ID_W),
    .AXI_WR_ID(4'd1),
    .CNT_W    (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .sb_store_data   (sb_store_data),
    .sb_store_addr   (sb_store_addr),
    .sb_store_rwen   (sb_store_rwen),
    .sb_store_en     (sb_store_en),
    .sb_store_uncache(sb_store_uncache),
    .cache_is_busy   (cache_is_busy),
    .dc_wr_req       (dc_wr_req),
    .dc_wr_addr      (dc_wr_addr),
    .dc_wr_data      (dc_wr_data),
    .dc_wr_wstrb     (dc_wr_wstrb),
    .dc_wr_ack       (dc_wr_ack),
    .awid            (awid),
    .awaddr          (awaddr),
    .awlen           (awlen),
    .awsize          (awsize),
    .awburst         (awburst),
    .awvalid         (awvalid),
    .awready         (awready),
    .wdata           (wdata),
    .wstrb           (wstrb),
    .wlast           (wlast),
    .wvalid          (wvalid),
    .wready          (wready),
    .bid             (bid),
    .bresp           (bresp),
    .bvalid          (bvalid),
    .bready          (bready),
    .bus_err         (bus_err),
    .cached_cnt      (cached_cnt),
    .uncached_cnt    (uncached_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        unc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  rwen;
  } st_t;

  st_t sbq[$];   // store buffer contents, head = sbq[0]
  st_t expq[$];  // popped stores awaiting retirement, in program order

  int tests_run = 0;
  int tests_failed = 0;
  int pops = 0;
  int n_push = 0;
  int n_cac = 0;
  int n_unc = 0;
  bit pop_pending = 1'b0;
  bit aw_seen = 1'b0;
  bit w_seen = 1'b0;
  bit m_err = 1'b0;
  bit fast = 1'b0;
  bit hold = 1'b0;
  int force_err = 0;  // 0 random, 1 always SLVERR, 2 always OKAY

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ref_size(input logic [3:0] be);
    if (be == 4'hF) return 3'd2;
    if (be == 4'h3 || be == 4'hC) return 3'd1;
    if ($countones(be) == 1) return 3'd0;
    return 3'd2;
  endfunction

  function automatic logic [31:0] ref_awaddr(input logic [31:0] a, input logic [3:0] be);
    logic [1:0] o;
    o = 2'd0;
    if (ref_size(be) == 3'd0) begin
      for (int i = 3; i >= 0; i--) if (be[i]) o = 2'(i);
    end else if (ref_size(be) == 3'd1) begin
      o = be[2] ? 2'd2 : 2'd0;
    end
    return {a[31:2], o};
  endfunction

  // Monitor / scoreboard: sample everything away from the rising edge.
  always @(negedge clk) begin
    bit  have;
    st_t h;
    st_t e;
    if (rst) begin
      expq.delete();
      aw_seen     = 1'b0;
      w_seen      = 1'b0;
      m_err       = 1'b0;
      pop_pending = 1'b0;
    end else begin
      have = (expq.size() != 0);
      h    = have ? expq[0] : '0;
      check("busy_iff_store_in_flight", cache_is_busy, have);
      if (dc_wr_req) begin
        check("dc_req_for_cached_head", have && !h.unc, 1'b1);
        if (dc_wr_ack) begin
          check("dc_wr_fields", {dc_wr_addr, dc_wr_data, dc_wr_wstrb},
                {h.addr, h.data, h.rwen});
          void'(expq.pop_front());
        end
      end
      if (awvalid) begin
        check("aw_once_for_uncached_head", have && h.unc && !aw_seen, 1'b1);
        if (awready) begin
          check("aw_fields", {awaddr, awsize, awlen, awburst, awid},
                {ref_awaddr(h.addr, h.rwen), ref_size(h.rwen), 8'd0, 2'b01, 4'd1});
          aw_seen = 1'b1;
        end
      end
      if (wvalid) begin
        check("w_once_for_uncached_head", have && h.unc && !w_seen, 1'b1);
        if (wready) begin
          check("w_fields", {wdata, wstrb, wlast}, {h.data, h.rwen, 1'b1});
          w_seen = 1'b1;
        end
      end
      if (bready) begin
        check("bready_after_aw_and_w", have && h.unc && aw_seen && w_seen, 1'b1);
        if (bvalid) begin
          if (bresp != 2'b00) m_err = 1'b1;
          aw_seen = 1'b0;
          w_seen  = 1'b0;
          void'(expq.pop_front());
        end
      end
      pop_pending = (sb_store_en || sb_store_uncache) && !cache_is_busy;
      if (pop_pending && sb_store_rwen != 4'b0000) begin
        e.unc  = sb_store_uncache;
        e.addr = sb_store_addr;
        e.data = sb_store_data;
        e.rwen = sb_store_rwen;
        expq.push_back(e);
      end
    end
  end

  // Store buffer model: the head leaves on the edge where the DUT was not busy.
  always @(posedge clk) begin
    #1;
    if (pop_pending) begin
      void'(sbq.pop_front());
      pops++;
    end
    if (sbq.size() != 0) begin
      sb_store_en      = !sbq[0].unc;
      sb_store_uncache = sbq[0].unc;
      sb_store_addr    = sbq[0].addr;
      sb_store_data    = sbq[0].data;
      sb_store_rwen    = sbq[0].rwen;
    end else begin
      sb_store_en      = 1'b0;
      sb_store_uncache = 1'b0;
      sb_store_addr    = '0;
      sb_store_data    = '0;
      sb_store_rwen    = '0;
    end
  end

  // Memory-side responders with random latency.
  always @(posedge clk) begin
    #1;
    dc_wr_ack = dc_wr_req && (fast || $urandom_range(0, 2) == 0);
    awready   = !hold && (fast || $urandom_range(0, 2) == 0);
    wready    = !hold && (fast || $urandom_range(0, 2) == 0);
    if (bready && !bvalid) begin
      bvalid = fast || $urandom_range(0, 2) == 0;
      bid    = 4'($urandom);
      if (force_err == 1) bresp = 2'b10;
      else if (force_err == 2) bresp = 2'b00;
      else bresp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
    end else if (!bready) begin
      bvalid = 1'b0;
    end
  end

  task automatic push(input logic unc, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
    st_t s;
    s.unc  = unc;
    s.addr = a;
    s.data = d;
    s.rwen = be;
    sbq.push_back(s);
    n_push++;
    if (be != 4'b0000) begin
      if (unc) n_unc++;
      else n_cac++;
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((sbq.size() != 0 || cache_is_busy || expq.size() != 0 || pop_pending) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_drained"}, t < 5000, 1'b1);
    check({name, "_cached_cnt"}, cached_cnt, n_cac);
    check({name, "_uncached_cnt"}, uncached_cnt, n_unc);
    check({name, "_pops"}, pops, n_push);
    check({name, "_bus_err"}, bus_err, m_err);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pats[12];
    int t;
    pats = '{4'h0, 4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h5, 4'hA, 4'hE, 4'h7};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {cache_is_busy, dc_wr_req, awvalid, wvalid, bready, bus_err}, 6'b0);
    check("reset_counters", {cached_cnt, uncached_cnt}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    push(1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 4'b1111);
    drain("cached_single");
    push(1'b1, 32'h1FD0_0003, 32'h1234_5678, 4'b1000);
    drain("uncached_byte");

    fast = 1'b1;
    push(1'b0, 32'h0000_2000, 32'h1111_1111, 4'b1111);
    push(1'b1, 32'h1FD0_0010, 32'h2222_2222, 4'b1100);
    push(1'b0, 32'h0000_2004, 32'h3333_3333, 4'b0011);
    drain("back_to_back");
    fast = 1'b0;

    force_err = 1;
    push(1'b1, 32'h1FD0_0020, 32'hBAD0_BAD0, 4'b1111);
    drain("slverr");
    check("bus_err_set", bus_err, 1'b1);
    force_err = 2;
    push(1'b1, 32'h1FD0_0024, 32'h0000_0001, 4'b0001);
    push(1'b1, 32'h1FD0_0028, 32'h0000_0002, 4'b0110);
    drain("after_slverr");
    check("bus_err_sticky", bus_err, 1'b1);
    force_err = 0;

    push(1'b0, 32'h0000_3000, 32'hFFFF_FFFF, 4'b0000);
    push(1'b1, 32'h1FD0_3000, 32'hFFFF_FFFF, 4'b0000);
    drain("noop_pops");

    for (int c = 0; c < 4; c++) begin
      fast = (c == 2);
      for (int i = 0; i < 60; i++) begin
        push(1'($urandom_range(0, 1)), $urandom, $urandom, pats[$urandom_range(0, 11)]);
      end
      drain("random_chunk");
      repeat ($urandom_range(1, 5)) @(posedge clk);
    end
    fast = 1'b0;

    // Reset while the AW/W channels are stalled mid-request.
    hold = 1'b1;
    push(1'b1, 32'h1FD0_4000, 32'hCAFE_F00D, 4'b1111);
    t = 0;
    while (!awvalid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("awvalid_before_reset", awvalid, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    hold   = 1'b0;
    n_cac  = 0;
    n_unc  = 0;
    n_push = 0;
    pops   = 0;
    @(negedge clk);
    check("reset_midflight_valids", {awvalid, wvalid, cache_is_busy}, 3'b000);
    check("reset_midflight_counters", {cached_cnt, uncached_cnt, 1'b0, bus_err}, 66'd0);
    push(1'b0, 32'h0000_5000, 32'h5555_AAAA, 4'b1111);
    drain("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
